// File: rtl/bcd2bin_pkg.sv
// Shared types and constants for the BCD-to-binary request arbiter.
// Holds the FSM encoding and the operand range check used during arbitration.
package bcd2bin_pkg;

    localparam int N_REQ   = 4;
    localparam int BCD_W   = 20;
    localparam int BIN_W   = 16;
    localparam int MAX_BIN = 65535;

    // MAX_BIN written as five BCD digits, so the check never needs a multiplier
    localparam logic [BCD_W-1:0] MAX_BCD = 20'h65535;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LOAD,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    function automatic logic bcd_invalid(input logic [BCD_W-1:0] v);
        logic       bad;
        logic       gt;
        logic       lt;
        logic [3:0] d;
        logic [3:0] m;
        bad = 1'b0;
        gt  = 1'b0;
        lt  = 1'b0;
        for (int i = BCD_W / 4 - 1; i >= 0; i--) begin
            d = v[4*i +: 4];
            m = MAX_BCD[4*i +: 4];
            if (d > 4'd9) bad = 1'b1;
            // first differing digit from the top decides the magnitude compare
            if (!gt && !lt) begin
                if (d > m)      gt = 1'b1;
                else if (d < m) lt = 1'b1;
            end
        end
        return bad | gt;
    endfunction

endpackage

// File: rtl/bcd2bin_rr_arb4.sv
// Four-way round-robin selector: first active request at or after rr_ptr.
module bcd2bin_rr_arb4
    import bcd2bin_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       rr_ptr,
    output logic [1:0]       grant,
    output logic             grant_valid
);

    logic [1:0] idx;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        // scan farthest-first so the closest requester to rr_ptr is written last
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = rr_ptr + 2'(k);
            if (req[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd2bin_arbiter.sv
// Arbitrates four BCD requesters onto one shared external bcd_to_bin_16 converter.
// Define BCD2BIN_ARB_TIMEOUT_EN to add a converter-done watchdog of TIMEOUT_CYC cycles.
module bcd2bin_arbiter
    import bcd2bin_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*BCD_W-1:0] bcd_in,
    output logic [N_REQ-1:0]       ack,
    output logic [BIN_W-1:0]       result,
    output logic                   result_valid,
    output logic [1:0]             result_id,
    output logic                   err,
    output logic                   busy,
    output logic                   cv_init,
    output logic [BCD_W-1:0]       cv_A,
    input  logic                   cv_done,
    input  logic [BIN_W-1:0]       cv_result
);

    state_t           state;
    state_t           nxt;
    logic [1:0]       rr_ptr;
    logic [1:0]       winner;
    logic             err_q;
    logic             conv_path;
    logic [1:0]       grant;
    logic             grant_valid;
    logic [BCD_W-1:0] sel_bcd;
    logic             sel_bad;
    logic             timeout;

    bcd2bin_rr_arb4 u_rr (
        .req         (req),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign sel_bcd = bcd_in[int'(grant)*BCD_W +: BCD_W];
    assign sel_bad = bcd_invalid(sel_bcd);

`ifdef BCD2BIN_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)               wait_cnt <= '0;
        else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
        else                      wait_cnt <= '0;
    end

    assign timeout = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic [31:0] unused_timeout_cyc;
    assign unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (|req) nxt = S_ARB;
            // a requester may withdraw between IDLE and ARB; then nothing is served
            S_ARB:   if (!grant_valid) nxt = S_IDLE;
                     else if (sel_bad) nxt = S_RESP;
                     else              nxt = S_LOAD;
            S_LOAD:  nxt = S_WAIT;
            S_WAIT:  if (cv_done || timeout) nxt = S_RESP;
            S_RESP:  nxt = conv_path ? S_DRAIN : S_IDLE;
            S_DRAIN: if (!cv_done) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ack          = '0;
        result_valid = (state == S_RESP);
        err          = (state == S_RESP) && err_q;
        busy         = (state != S_IDLE);
        cv_init      = (state == S_LOAD) || (state == S_WAIT);
        if (state == S_RESP) ack[winner] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= '0;
            winner    <= '0;
            err_q     <= 1'b0;
            conv_path <= 1'b0;
            cv_A      <= '0;
            result    <= '0;
        end else begin
            if (state == S_ARB && grant_valid) begin
                winner    <= grant;
                rr_ptr    <= grant + 2'd1;
                err_q     <= sel_bad;
                conv_path <= !sel_bad;
                if (sel_bad) result <= '0;
                else         cv_A   <= sel_bcd;
            end
            if (state == S_WAIT) begin
                if (cv_done) begin
                    result <= cv_result;
                end else if (timeout) begin
                    result <= '0;
                    err_q  <= 1'b1;
                end
            end
        end
    end

    assign result_id = winner;

endmodule

// File: tb/tb_bcd2bin_arbiter.sv
// Bench for bcd2bin_arbiter: vector table, round-robin sequence, mid-transaction reset,
// and (with BCD2BIN_ARB_TIMEOUT_EN) the converter watchdog; results go through a scoreboard.
module tb_bcd2bin_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [79:0] bcd_in;
    logic [3:0]  ack;
    logic [15:0] result;
    logic        result_valid;
    logic [1:0]  result_id;
    logic        err;
    logic        busy;
    logic        cv_init;
    logic [19:0] cv_A;
    logic        cv_done;
    logic [15:0] cv_result;

    bcd2bin_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .bcd_in       (bcd_in),
        .ack          (ack),
        .result       (result),
        .result_valid (result_valid),
        .result_id    (result_id),
        .err          (err),
        .busy         (busy),
        .cv_init      (cv_init),
        .cv_A         (cv_A),
        .cv_done      (cv_done),
        .cv_result    (cv_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [19:0] bcd;
        logic [15:0] res;
        logic        err;
    } vec_t;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] res;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   conv_delay = 17;
    bit   conv_stuck = 1'b0;
    int   conv_cnt = 0;
    bit   init_seen = 1'b0;
    int   init_cycles = 0;

    function automatic logic [15:0] bcd2int(input logic [19:0] v);
        int acc;
        acc = 0;
        for (int i = 4; i >= 0; i--) acc = acc * 10 + int'(v[4*i +: 4]);
        return 16'(acc);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural shared converter: done rises conv_delay cycles after init, clears when init drops
    always @(posedge clk) begin
        if (!cv_init) begin
            conv_cnt <= 0;
            cv_done  <= 1'b0;
        end else if (!conv_stuck && conv_cnt >= conv_delay - 1) begin
            cv_done   <= 1'b1;
            cv_result <= bcd2int(cv_A);
        end else begin
            conv_cnt <= conv_cnt + 1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (cv_init) begin
            init_seen = 1'b1;
            init_cycles++;
        end
        if (result_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: id %0d result %0d with empty scoreboard", result_id, result);
            end else begin
                e = sb.pop_front();
                check("result_id", 32'(result_id), 32'(e.id));
                check("result", 32'(result), 32'(e.res));
                check("err", 32'(err), 32'(e.err));
                check("ack", 32'(ack), 32'(4'b0001 << e.id));
            end
        end
    end

    task automatic wait_ack(input logic [3:0] mask, output logic [3:0] got);
        bit found;
        found = 1'b0;
        got   = '0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if ((ack & mask) != 0) begin
                found = 1'b1;
                got   = ack;
            end
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout: no ack within 300 cycles for mask 0x%0h", mask);
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic serve(input logic [1:0] id, input logic [19:0] bcd, input logic [15:0] res,
                         input logic e);
        logic [3:0] got;
        exp_t x;
        bcd_in[int'(id)*20 +: 20] = bcd;
        x.id = id; x.res = res; x.err = e;
        sb.push_back(x);
        init_seen = 1'b0;
        req[id]   = 1'b1;
        wait_ack(4'b0001 << id, got);
        req = '0;
        wait_idle();
        check("cv_init_used", 32'(init_seen), 32'(!e));
        if (!e) check("result_hold", 32'(result), 32'(res));
    endtask

    vec_t vecs[10];

    initial begin
        logic [3:0] got;
        exp_t x;

        vecs[0] = '{2'd0, 20'h01234, 16'd1234,  1'b0};
        vecs[1] = '{2'd2, 20'h0A000, 16'd0,     1'b1};
        vecs[2] = '{2'd1, 20'h65535, 16'd65535, 1'b0};
        vecs[3] = '{2'd1, 20'h65536, 16'd0,     1'b1};
        vecs[4] = '{2'd3, 20'h00000, 16'd0,     1'b0};
        vecs[5] = '{2'd0, 20'h99999, 16'd0,     1'b1};
        vecs[6] = '{2'd2, 20'h59999, 16'd59999, 1'b0};
        vecs[7] = '{2'd3, 20'h6553F, 16'd0,     1'b1};
        vecs[8] = '{2'd1, 20'h66000, 16'd0,     1'b1};
        vecs[9] = '{2'd0, 20'h09999, 16'd9999,  1'b0};

        reset     = 1'b0;
        req       = '0;
        bcd_in    = '0;
        cv_done   = 1'b0;
        cv_result = '0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 32'({ack, result_valid, err, busy, cv_init}), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_result_id", 32'(result_id), 32'd0);
        check("rst_cv_A", 32'(cv_A), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) serve(vecs[i].id, vecs[i].bcd, vecs[i].res, vecs[i].err);

        // all four requesting from reset: served 0,1,2,3, then the pointer wraps to 0
        reset = 1'b0;
        @(negedge clk);
        reset  = 1'b1;
        conv_delay = 3;
        bcd_in = {20'h00044, 20'h00033, 20'h00022, 20'h00011};
        for (int i = 0; i < 4; i++) begin
            x.id = 2'(i); x.res = 16'(11 * (i + 1)); x.err = 1'b0;
            sb.push_back(x);
        end
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_ack(4'b1111, got);
            req = req & ~got;
        end
        wait_idle();
        for (int i = 0; i < 2; i++) begin
            x.id = 2'(i); x.res = 16'(11 * (i + 1)); x.err = 1'b0;
            sb.push_back(x);
        end
        req = 4'b0011;
        for (int i = 0; i < 2; i++) begin
            wait_ack(4'b0011, got);
            req = req & ~got;
        end
        wait_idle();

        // reset while waiting on the converter drops the transaction silently
        conv_delay = 17;
        bcd_in[79:60] = 20'h00777;
        req = 4'b1000;
        for (int c = 0; c < 20 && !cv_init; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("in_wait_before_reset", 32'(cv_init), 32'd1);
        reset = 1'b0;
        #1;
        check("reset_cv_init", 32'(cv_init), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ack", 32'(ack), 32'd0);
        req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        serve(2'd3, 20'h00042, 16'd42, 1'b0);

`ifdef BCD2BIN_ARB_TIMEOUT_EN
        conv_stuck  = 1'b1;
        init_cycles = 0;
        bcd_in[19:0] = 20'h00001;
        x.id = 2'd0; x.res = 16'd0; x.err = 1'b1;
        sb.push_back(x);
        req = 4'b0001;
        wait_ack(4'b0001, got);
        req = '0;
        check("timeout_init_cycles", 32'(init_cycles), 32'(TO + 1));
        wait_idle();
        conv_stuck = 1'b0;
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd2bin_arbiter.md
BCD2BIN_ARBITER -- requirements
Module: bcd2bin_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, 255, converter-done watchdog limit in cycles; used only when BCD2BIN_ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  per-requester conversion request; level, held until ack.
REQ-005 bcd_in  input  80  four packed 20-bit, 5-digit BCD operands; requester i uses bits [20i+19:20i]; stable while req[i] is high.
REQ-006 ack  output  4  one-cycle pulse to the served requester.
REQ-007 result  output  16  binary result, valid while result_valid is high.
REQ-008 result_valid  output  1  one-cycle pulse, coincident with ack.
REQ-009 result_id  output  2  index of the served requester, valid with result_valid.
REQ-010 err  output  1  error flag, valid with result_valid; result is 0 when err is high.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 cv_init  output  1  start signal to the shared bcd_to_bin_16 converter.
REQ-013 cv_A  output  20  operand to the converter.
REQ-014 cv_done  input  1  converter completion.
REQ-015 cv_result  input  16  converter output.

Function
REQ-016 FSM states: IDLE, ARB, LOAD, WAIT, RESP, DRAIN.
REQ-017 IDLE -> ARB when any req bit is high; otherwise stay in IDLE.
REQ-018 ARB:
- Round-robin pick starting at rr_ptr, wrapping 3->0.
- Register the winner index and its bcd_in slice.
- Set rr_ptr = winner+1 (mod 4).
REQ-019 ARB also checks the captured operand:
- Any digit > 9 -> err.
- Value > 65535 (digit-wise compare against 6,5,5,3,5) -> err.
- On err, go to RESP without starting the converter; otherwise go to LOAD.
REQ-020 LOAD: drive cv_A = captured operand and cv_init = 1; go to WAIT next cycle.
REQ-021 WAIT: hold cv_init = 1; on cv_done = 1, capture cv_result and go to RESP.
REQ-022 RESP (one cycle): pulse ack[winner] and result_valid; drive result_id = winner and err; cv_init = 0.
- After an err path, go to IDLE.
- After a converter path, go to DRAIN.
REQ-023 DRAIN: cv_init = 0; go to IDLE once cv_done = 0, so the converter is idle before the next start.
REQ-024 Minimum latency for a valid operand, req high to ack: 4 cycles + converter time. Minimum for an err operand: 3 cycles.
REQ-025 req changes outside IDLE/ARB are ignored; a requester that drops req before ack still receives ack.
REQ-026 Simultaneous requests are served one per transaction in round-robin order; no requester waits more than 3 other transactions.
REQ-027 cv_A, result and result_id hold their last values between transactions.

Reset
REQ-028 While reset = 0:
- State = IDLE, rr_ptr = 0.
- ack, result_valid, err, busy, cv_init = 0.
- result, result_id, cv_A = 0.
REQ-029 Reset mid-transaction drops the transaction silently: no ack, and cv_init falls immediately.

Configuration
REQ-030 Macro BCD2BIN_ARB_TIMEOUT_EN.
- Defined: a WAIT cycle counter runs; reaching TIMEOUT_CYC without cv_done forces RESP with err = 1, result = 0, then DRAIN.
- Undefined: no counter, and WAIT waits indefinitely.

Structure
REQ-031 Package bcd2bin_pkg holds: the FSM state encoding; constants N_REQ = 4, BCD_W = 20, BIN_W = 16, MAX_BIN = 65535.
REQ-032 Round-robin selection is a separate sub-module, bcd2bin_rr_arb4 (inputs req and rr_ptr; outputs grant index and valid).
REQ-033 The converter instance is external to this block.

Verification
REQ-034 Single request: req = 0001, slice0 = 0x01234, converter done after 17 cycles -> ack = 0001, result = 1234, result_id = 0, err = 0.
REQ-035 All four req high from reset, all operands valid -> result_id sequence 0,1,2,3; rr_ptr then restarts the next round at 0.
REQ-036 Invalid digit: req = 0100, slice2 = 0x0A000 -> ack = 0100, err = 1, result = 0, cv_init never asserted.
REQ-037 Overflow boundary: slice1 = 0x65535 -> result = 65535, err = 0; slice1 = 0x65536 -> err = 1.
REQ-038 Reset asserted in WAIT with req = 1000 -> cv_init = 0 and busy = 0 immediately; no ack; after reset, the next request is served normally.
REQ-039 With BCD2BIN_ARB_TIMEOUT_EN and TIMEOUT_CYC = 8, cv_done held low -> ack and err = 1 after 8 WAIT cycles, then IDLE once cv_done = 0.
